// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: word width, receiver states and default
// 50 MHz pulse timings also used by the matching encoder.
package ws2812b_pkg;

  localparam int RGB_W        = 24;

  localparam int T0H          = 20;
  localparam int T0L          = 42;
  localparam int T1H          = 40;
  localparam int T1L          = 22;
  localparam int RESET_CYCLES = 2500;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HIGH,
    LOW
  } rx_state_t;

endpackage

// File: rtl/ws2812b_din_sync.sv
// Brings the asynchronous WS2812B line into sys_clk: two-flop synchronizer
// plus one delay stage for single-cycle edge strobes.
module ws2812b_din_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    level = s2;
    rise  = s2 & ~s3;
    fall  = ~s2 & s3;
  end

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receiver: measures high-pulse widths to recover GRB words, and
// uses the long low reset gap to delimit frames.
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int NUM_LEDS     = 64,
  parameter int BIT_THRESH   = 30,
  parameter int MIN_HIGH     = 5,
  parameter int MAX_HIGH     = 75,
  parameter int RESET_CYCLES = ws2812b_pkg::RESET_CYCLES
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          din,
  output logic [RGB_W-1:0]              rgb_data,
  output logic                          rgb_valid,
  output logic [$clog2(NUM_LEDS)-1:0]   led_index,
  output logic                          frame_done,
  output logic [$clog2(NUM_LEDS+1)-1:0] frame_len,
  output logic                          bit_err
);

  localparam int IDX_W = $clog2(NUM_LEDS);
  localparam int CNT_W = $clog2(NUM_LEDS + 1);
  localparam int HC_W  = $clog2(MAX_HIGH + 2);
  localparam int LC_W  = $clog2(RESET_CYCLES + 1);
  localparam int BC_W  = $clog2(RGB_W);

  localparam logic [HC_W-1:0]  HC_THR  = HC_W'(BIT_THRESH);
  localparam logic [HC_W-1:0]  HC_MIN  = HC_W'(MIN_HIGH);
  localparam logic [HC_W-1:0]  HC_MAX  = HC_W'(MAX_HIGH);
  localparam logic [HC_W-1:0]  HC_SAT  = HC_W'(MAX_HIGH + 1);
  localparam logic [LC_W-1:0]  LC_END  = LC_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] WC_MAX  = CNT_W'(NUM_LEDS);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(RGB_W - 1);

  logic level;
  logic rise;
  logic fall;

  ws2812b_din_sync u_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .din     (din),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  rx_state_t        state;
  rx_state_t        state_nx;
  logic [HC_W-1:0]  high_cnt;
  logic [LC_W-1:0]  low_cnt;
  logic [BC_W-1:0]  bit_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic [RGB_W-2:0] shreg;

  logic bit_val;
  logic shift_en;
  logic word_done;
  logic err;
  logic frame_end;
  logic abort;

  // high_cnt holds the exact number of high cycles by the time fall strobes
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      high_cnt <= '0;
    end else if (rise) begin
      high_cnt <= HC_W'(1);
    end else if (level && high_cnt != HC_SAT) begin
      high_cnt <= high_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || level) begin
      low_cnt <= '0;
    end else if (low_cnt != LC_END) begin
      low_cnt <= low_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A rise landing on the gap-detect cycle still starts a bit, so no pulse is lost
  always_comb begin
    state_nx  = state;
    shift_en  = 1'b0;
    word_done = 1'b0;
    err       = 1'b0;
    frame_end = 1'b0;
    abort     = 1'b0;
    bit_val   = (high_cnt >= HC_THR);
    unique case (state)
      IDLE: begin
        if (low_cnt == LC_END) begin
          state_nx = rise ? HIGH : ARMED;
        end
      end
      ARMED: begin
        if (rise) begin
          state_nx = HIGH;
        end
      end
      HIGH: begin
        if (high_cnt > HC_MAX) begin
          err      = 1'b1;
          abort    = 1'b1;
          state_nx = IDLE;
        end else if (fall) begin
          if (high_cnt < HC_MIN) begin
            err      = 1'b1;
            abort    = 1'b1;
            state_nx = IDLE;
          end else begin
            shift_en  = 1'b1;
            word_done = (bit_cnt == BC_LAST);
            state_nx  = LOW;
          end
        end
      end
      LOW: begin
        if (low_cnt == LC_END) begin
          frame_end = 1'b1;
          err       = (bit_cnt != '0);
          state_nx  = rise ? HIGH : ARMED;
        end else if (rise) begin
          state_nx = HIGH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      rgb_data   <= '0;
      rgb_valid  <= 1'b0;
      led_index  <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      bit_err    <= 1'b0;
    end else begin
      rgb_valid  <= 1'b0;
      frame_done <= 1'b0;
      bit_err    <= err;
      shreg      <= shreg;
      if (shift_en) begin
        shreg <= {shreg[RGB_W-3:0], bit_val};
        if (word_done) begin
          bit_cnt <= '0;
          if (word_cnt < WC_MAX) begin
            rgb_data  <= {shreg, bit_val};
            rgb_valid <= 1'b1;
            led_index <= word_cnt[IDX_W-1:0];
            word_cnt  <= word_cnt + 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (frame_end) begin
        frame_done <= 1'b1;
        frame_len  <= word_cnt;
        word_cnt   <= '0;
        bit_cnt    <= '0;
      end
      if (abort) begin
        word_cnt <= '0;
        bit_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed and randomized pulse trains for ws2812b_rx, scored against a
// pulse-level reference model of the WS2812B decoding rules.
module tb_ws2812b_rx;

  localparam int NUM_LEDS   = 64;
  localparam int BIT_THRESH = 30;
  localparam int MIN_HIGH   = 5;
  localparam int MAX_HIGH   = 75;
  localparam int RST_CYC    = 2500;
  localparam int GAP        = 2520;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic [23:0] rgb_data;
  logic        rgb_valid;
  logic [5:0]  led_index;
  logic        frame_done;
  logic [6:0]  frame_len;
  logic        bit_err;

  ws2812b_rx #(
    .NUM_LEDS     (NUM_LEDS),
    .BIT_THRESH   (BIT_THRESH),
    .MIN_HIGH     (MIN_HIGH),
    .MAX_HIGH     (MAX_HIGH),
    .RESET_CYCLES (RST_CYC)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .din        (din),
    .rgb_data   (rgb_data),
    .rgb_valid  (rgb_valid),
    .led_index  (led_index),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .bit_err    (bit_err)
  );

  always #10 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [29:0] exp_w[$];
  logic [29:0] got_w[$];
  logic [7:0]  exp_f[$];
  logic [7:0]  got_f[$];
  int          exp_err = 0;
  int          got_err = 0;

  // reference model: live = decoding allowed, inframe = bits seen since arming
  bit          m_live     = 1'b0;
  bit          m_inframe  = 1'b0;
  int          m_nbits    = 0;
  logic [23:0] m_word     = '0;
  int          m_wc       = 0;
  int          m_low      = 0;
  bit          m_gap_done = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rgb_valid)  got_w.push_back({led_index, rgb_data});
      if (frame_done) got_f.push_back({bit_err, frame_len});
      if (bit_err)    got_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    return (i < got_w.size()) ? 32'(got_w[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] frame_at(input int i);
    return (i < got_f.size()) ? 32'(got_f[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic void model_reset();
    m_live = 1'b0; m_inframe = 1'b0; m_nbits = 0; m_wc = 0;
    m_low = 0; m_gap_done = 1'b0;
  endfunction

  function automatic void model_high(input int h);
    m_low = 0;
    m_gap_done = 1'b0;
    if (!m_live) return;
    if (h < MIN_HIGH || h > MAX_HIGH) begin
      exp_err++;
      m_live = 1'b0; m_inframe = 1'b0; m_nbits = 0; m_wc = 0;
      return;
    end
    m_inframe = 1'b1;
    m_word = {m_word[22:0], (h >= BIT_THRESH)};
    m_nbits++;
    if (m_nbits == 24) begin
      if (m_wc < NUM_LEDS) begin
        exp_w.push_back({6'(m_wc), m_word});
        m_wc++;
      end
      m_nbits = 0;
    end
  endfunction

  function automatic void model_low(input int l);
    m_low += l;
    if (!m_gap_done && m_low > RST_CYC) begin
      m_gap_done = 1'b1;
      if (m_live && m_inframe) begin
        exp_f.push_back({(m_nbits != 0), 7'(m_wc)});
        if (m_nbits != 0) exp_err++;
      end
      m_live = 1'b1; m_inframe = 1'b0; m_nbits = 0; m_wc = 0;
    end
  endfunction

  task automatic pulse(input int h, input int l);
    din = 1'b1;
    repeat (h) @(negedge clk);
    model_high(h);
    din = 1'b0;
    repeat (l) @(negedge clk);
    model_low(l);
  endtask

  task automatic gap(input int l);
    din = 1'b0;
    repeat (l) @(negedge clk);
    model_low(l);
  endtask

  // speed 0: nominal timings, 1: random legal jitter, 2: short legal pulses
  task automatic send_bit(input bit b, input int speed);
    case (speed)
      0:       if (b) pulse(ws2812b_pkg::T1H, ws2812b_pkg::T1L);
               else   pulse(ws2812b_pkg::T0H, ws2812b_pkg::T0L);
      1:       if (b) pulse(int'($urandom_range(MAX_HIGH, BIT_THRESH)), int'($urandom_range(20, 3)));
               else   pulse(int'($urandom_range(BIT_THRESH - 1, MIN_HIGH)), int'($urandom_range(20, 3)));
      default: if (b) pulse(int'($urandom_range(32, BIT_THRESH)), int'($urandom_range(4, 2)));
               else   pulse(int'($urandom_range(8, MIN_HIGH)), int'($urandom_range(4, 2)));
    endcase
  endtask

  task automatic send_bits(input logic [23:0] d, input int n, input int speed);
    for (int i = 0; i < n; i++) send_bit(d[23-i], speed);
  endtask

  task automatic verify(input string tag);
    int nw;
    int nf;
    check({tag, "_nwords"}, got_w.size(), exp_w.size());
    nw = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < nw; i++) check({tag, "_word"}, got_w[i], exp_w[i]);
    check({tag, "_nframes"}, got_f.size(), exp_f.size());
    nf = (got_f.size() < exp_f.size()) ? got_f.size() : exp_f.size();
    for (int i = 0; i < nf; i++) check({tag, "_frame"}, got_f[i], exp_f[i]);
    check({tag, "_errs"}, got_err, exp_err);
    got_w.delete(); exp_w.delete(); got_f.delete(); exp_f.delete();
    got_err = 0; exp_err = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rgb_data"},   rgb_data,   '0);
    check({tag, "_rgb_valid"},  rgb_valid,  '0);
    check({tag, "_led_index"},  led_index,  '0);
    check({tag, "_frame_done"}, frame_done, '0);
    check({tag, "_frame_len"},  frame_len,  '0);
    check({tag, "_bit_err"},    bit_err,    '0);
  endtask

  initial begin
    logic [23:0] d;
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    model_reset();

    // single nominal-timing word
    gap(GAP);
    send_bits(24'hFF0000, 24, 0);
    gap(GAP);
    check("s1_word_const", word_at(0), {8'h0, 6'd0, 24'hFF0000});
    check("s1_frame_const", frame_at(0), {24'h0, 1'b0, 7'd1});
    verify("s1");

    // 66 words: indices 0..63 in order, last two dropped
    for (int i = 0; i < 66; i++) send_bits((i % 2 == 0) ? 24'h00FF00 : 24'h0000FF, 24, 2);
    gap(GAP);
    check("s2_last_word_const", word_at(63), {8'h0, 6'd63, 24'h0000FF});
    check("s2_frame_const", frame_at(0), {24'h0, 1'b0, 7'd64});
    verify("s2");

    // high-time boundaries: 29 -> 0, 30 -> 1, 75 -> 1, 5 -> 0
    pulse(29, 10); pulse(30, 10); pulse(75, 10); pulse(5, 10);
    for (int i = 0; i < 20; i++) pulse(20, 10);
    send_bits(24'($urandom), 24, 1);
    gap(GAP);
    check("s3_bound_const", word_at(0), {8'h0, 6'd0, 24'h600000});
    verify("s3");

    // over-long high aborts; decoding resumes only after a fresh gap
    send_bits(24'($urandom), 5, 1);
    pulse(76, 10);
    send_bits(24'($urandom), 24, 1);
    gap(GAP);
    send_bits(24'($urandom), 24, 1);
    gap(GAP);
    verify("s4");

    // glitch mid-word, then a partial word cut off by a gap
    send_bits(24'($urandom), 7, 1);
    pulse(3, 10);
    send_bits(24'($urandom), 16, 1);
    gap(GAP);
    send_bits(24'($urandom), 10, 1);
    gap(GAP);
    check("s5_partial_const", frame_at(0), {24'h0, 1'b1, 7'd0});
    verify("s5");

    // randomized frames
    for (int f = 0; f < 2; f++) begin
      int nwords;
      nwords = int'($urandom_range(3, 1));
      for (int w = 0; w < nwords; w++) begin
        d = 24'($urandom);
        send_bits(d, 24, 1);
      end
      gap(GAP);
    end
    verify("s6");

    // reset mid-word: outputs clear, following word ignored until a gap
    send_bits(24'($urandom), 12, 1);
    gap(10);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    model_reset();
    send_bits(24'($urandom), 24, 1);
    gap(GAP);
    send_bits(24'($urandom), 24, 1);
    gap(GAP);
    verify("s7");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ws2812b_rx.md
Name: ws2812b_rx

Overview:
- Decodes a WS2812B single-wire 0/1-code waveform back into 24-bit GRB words and frame boundaries.
- It is the receiving end of the pulse encoder that drives data_pwm.
- Used as a loopback checker on the LED data line, and as a monitor for a matrix DOUT chain.
- Feeds decoded words to a frame-compare or debug block in the 8x8 (64-LED) matrix design.

Parameters:
- NUM_LEDS, 64, number of words accepted per frame; later words are dropped.
- BIT_THRESH, 30, high-time cycles at or above which a bit decodes as 1 (0.6 us at 50 MHz).
- MIN_HIGH, 5, high pulses shorter than this are glitches and raise an error.
- MAX_HIGH, 75, high pulses longer than this are protocol errors.
- RESET_CYCLES, 2500, low time that marks frame end / reset gap (50 us at 50 MHz).

Ports:
- sys_clk, input, 1, system clock, 50 MHz.
- sys_rst, input, 1, synchronous active-high reset.
- din, input, 1, asynchronous WS2812B serial line.
- rgb_data, output, 24, last decoded word, MSB first as received (G[7:0],R[7:0],B[7:0]).
- rgb_valid, output, 1, one-cycle pulse when rgb_data is updated.
- led_index, output, $clog2(NUM_LEDS), index of the word in rgb_data within the current frame.
- frame_done, output, 1, one-cycle pulse at detection of a reset gap after at least one bit.
- frame_len, output, $clog2(NUM_LEDS+1), words received in the frame just ended; saturates at NUM_LEDS.
- bit_err, output, 1, one-cycle pulse on glitch, over-long high, or partial word at frame end.

Behaviour:
- Clocking/reset: one clock, sys_clk. Reset is synchronous, active-high, on sys_rst.
- Reset values: all outputs 0, state IDLE, all counters 0. Asserting sys_rst mid-word discards the word and emits no pulses.
- Input conditioning: din passes through a 2-FF synchronizer (s1, s2) plus a delay stage s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - All outputs are registered. Latency from din falling (first sampled low) to rgb_valid is 3 sys_clk edges.
- high_cnt counts cycles with s2=1. low_cnt counts cycles with s2=0 and saturates at RESET_CYCLES.
- State IDLE: wait for low_cnt == RESET_CYCLES, then go to ARMED. Highs seen in IDLE are ignored, so the block never decodes mid-frame after reset or after an error.
- State ARMED: on rise, clear high_cnt and go to HIGH.
- State HIGH:
  - If high_cnt exceeds MAX_HIGH: pulse bit_err, go to IDLE.
  - On fall with high_cnt < MIN_HIGH: pulse bit_err, go to IDLE.
  - Otherwise on fall: bit = (high_cnt >= BIT_THRESH). Shift the bit into shreg[23:0] MSB-first, increment bit_cnt, clear low_cnt, go to LOW.
  - When bit_cnt reaches 24:
    - If word_cnt < NUM_LEDS: rgb_data <= {shreg[22:0],bit}, rgb_valid=1, led_index=word_cnt, word_cnt++.
    - Otherwise the word is dropped with no pulse and word_cnt saturates.
    - bit_cnt returns to 0.
- State LOW:
  - On rise: clear high_cnt, go to HIGH.
  - If low_cnt reaches RESET_CYCLES: frame_done=1, frame_len=word_cnt. If bit_cnt != 0, also pulse bit_err in the same cycle and discard the partial word. Clear word_cnt and bit_cnt, go to ARMED.
- Boundary rules:
  - High of exactly BIT_THRESH decodes as 1.
  - High of exactly MIN_HIGH or exactly MAX_HIGH is legal.
  - No frame_done is issued for a gap that follows no bits (ARMED stays ARMED).
- Simultaneous events:
  - The last word's rgb_valid and frame_done can never coincide, because a frame end needs RESET_CYCLES of low.
  - bit_err and frame_done may coincide only in the partial-word case above.

Decomposition:
- Shared package ws2812b_pkg holds:
  - RGB_W=24 and the state enum {IDLE, ARMED, HIGH, LOW}.
  - Default timing constants (T0H=20, T0L=42, T1H=40, T1L=22, RESET_CYCLES=2500 at 50 MHz), shared with the encoder.
- One sub-module, ws2812b_din_sync: 2-FF synchronizer plus delay stage, outputs level, rise and fall.

Test Plan:
- Reset gap of 2600 cycles low, then one word 0xFF0000 (T1H/T1L x8, T0H/T0L x16), then 2600 low -> one rgb_valid with rgb_data=0xFF0000, led_index=0; then frame_done with frame_len=1; bit_err never asserted.
- 64 words alternating 0x00FF00 / 0x0000FF followed by reset gap -> 64 rgb_valid pulses, led_index 0..63 in order, frame_done with frame_len=64.
- 66 words in one frame -> exactly 64 rgb_valid pulses, words 64 and 65 dropped, frame_len=64, no bit_err.
- High pulses of 29, 30 and 75 cycles -> decoded as bits 0, 1 and 1. A 76-cycle high -> bit_err pulse, state IDLE, next word ignored until a new 2500-cycle gap.
- 3-cycle glitch high mid-word -> bit_err, no rgb_valid. 10 bits then reset gap (when armed) -> frame_done and bit_err in the same cycle, frame_len=0.
- sys_rst asserted for 1 cycle after 12 bits of a word -> all outputs 0, no pulses. The next word before a fresh reset gap is ignored; after a 2500-cycle gap it decodes correctly.
